// File: rtl/dice_roller.sv
// rtl/dice_roller.sv - multi-die electronic dice with odometer advance and minimum roll length
// Rolls while button is held, then freezes and registers the sum and a doubles flag.
module dice_roller #(
    parameter int FACES    = 6,
    parameter int NDICE    = 2,
    parameter int MIN_ROLL = 4,
    localparam int W       = $clog2(FACES + 1),
    localparam int SW      = $clog2(NDICE * FACES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 button,
    output logic [NDICE*W-1:0]   throw,
    output logic [SW-1:0]        sum,
    output logic                 all_equal,
    output logic                 rolling,
    output logic                 done
);

    localparam int CW = 11;
    localparam logic [W-1:0]  FACES_W = W'(FACES);
    localparam logic [W-1:0]  ONE_W   = W'(1);
    localparam logic [CW-1:0] MIN_C   = CW'(MIN_ROLL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic {
        IDLE,
        ROLL
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   die_q [NDICE];
    logic [W-1:0]   die_d [NDICE];
    logic [W-1:0]   adv_die [NDICE];
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]  sum_q, sum_d;
    logic           eq_q, eq_d;
    logic           done_q, done_d;
    logic           rolling_q, rolling_d;
    logic [SW-1:0]  cur_sum;
    logic           cur_eq;

    // Odometer: die k steps only when every lower die is about to wrap.
    always_comb begin
        logic carry;
        carry = 1'b1;
        for (int k = 0; k < NDICE; k++) begin
            adv_die[k] = die_q[k];
            if (carry) begin
                adv_die[k] = (die_q[k] == FACES_W) ? ONE_W : die_q[k] + ONE_W;
            end
            carry = carry & (die_q[k] == FACES_W);
        end
    end

    always_comb begin
        cur_sum = '0;
        cur_eq  = 1'b1;
        for (int k = 0; k < NDICE; k++) begin
            cur_sum = cur_sum + SW'(die_q[k]);
            if (die_q[k] != die_q[0]) begin
                cur_eq = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        die_d     = die_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        eq_d      = eq_q;
        done_d    = 1'b0;
        rolling_d = rolling_q;
        unique case (state_q)
            IDLE: begin
                if (button) begin
                    die_d     = adv_die;
                    cnt_d     = ONE_C;
                    state_d   = ROLL;
                    rolling_d = 1'b1;
                end
            end
            ROLL: begin
                if (button) begin
                    die_d = adv_die;
                    cnt_d = (cnt_q >= MIN_C) ? cnt_q : cnt_q + ONE_C;
                end else if (cnt_q < MIN_C) begin
                    die_d = adv_die;
                    cnt_d = cnt_q + ONE_C;
                end else begin
                    sum_d     = cur_sum;
                    eq_d      = cur_eq;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                    rolling_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            for (int k = 0; k < NDICE; k++) begin
                die_q[k] <= ONE_W;
            end
            cnt_q     <= '0;
            sum_q     <= SW'(NDICE);
            eq_q      <= 1'b1;
            done_q    <= 1'b0;
            rolling_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            die_q     <= die_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            eq_q      <= eq_d;
            done_q    <= done_d;
            rolling_q <= rolling_d;
        end
    end

    always_comb begin
        throw = '0;
        for (int k = 0; k < NDICE; k++) begin
            throw[k*W +: W] = die_q[k];
        end
    end

    assign sum       = sum_q;
    assign all_equal = eq_q;
    assign rolling   = rolling_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dice_roller.sv
// tb/tb_dice_roller.sv - self-checking bench for dice_roller
// Model tracks the roll as a step count and derives dice values arithmetically.
module tb_dice_roller;

    localparam int FACES    = 6;
    localparam int NDICE    = 2;
    localparam int MIN_ROLL = 4;
    localparam int W        = $clog2(FACES + 1);
    localparam int SW       = $clog2(NDICE * FACES + 1);

    logic                clk;
    logic                rst;
    logic                button;
    logic [NDICE*W-1:0]  throw;
    logic [SW-1:0]       sum;
    logic                all_equal;
    logic                rolling;
    logic                done;

    int checks   = 0;
    int failures = 0;

    dice_roller #(
        .FACES    (FACES),
        .NDICE    (NDICE),
        .MIN_ROLL (MIN_ROLL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .button    (button),
        .throw     (throw),
        .sum       (sum),
        .all_equal (all_equal),
        .rolling   (rolling),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int m_steps;
    int m_cnt;
    int m_sum;
    bit m_roll;
    bit m_done;
    bit m_eq;
    bit chk_en = 1'b0;
    int total_states;

    function automatic int die_val(int steps, int k);
        int r;
        r = steps;
        for (int i = 0; i < k; i++) r = r / FACES;
        return (r % FACES) + 1;
    endfunction

    function automatic logic [NDICE*W-1:0] model_throw(int steps);
        logic [NDICE*W-1:0] t;
        t = '0;
        for (int k = 0; k < NDICE; k++) t[k*W +: W] = W'(die_val(steps, k));
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        total_states = 1;
        for (int k = 0; k < NDICE; k++) total_states = total_states * FACES;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_steps = 0; m_roll = 0; m_cnt = 0; m_done = 0;
            m_sum = NDICE; m_eq = 1; chk_en = 1;
        end else begin
            m_done = 0;
            if (!m_roll) begin
                if (button) begin
                    m_steps = (m_steps + 1) % total_states;
                    m_cnt = 1; m_roll = 1;
                end
            end else if (button || m_cnt < MIN_ROLL) begin
                m_steps = (m_steps + 1) % total_states;
                if (m_cnt < MIN_ROLL) m_cnt++;
            end else begin
                m_sum = 0; m_eq = 1;
                for (int k = 0; k < NDICE; k++) begin
                    m_sum += die_val(m_steps, k);
                    if (die_val(m_steps, k) != die_val(m_steps, 0)) m_eq = 0;
                end
                m_done = 1; m_roll = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_throw", 32'(throw), 32'(model_throw(m_steps)));
            chk("model_sum", 32'(sum), 32'(m_sum));
            chk("model_all_equal", 32'(all_equal), 32'(m_eq));
            chk("model_rolling", 32'(rolling), 32'(m_roll));
            chk("model_done", 32'(done), 32'(m_done));
        end
    end

    task automatic drive(bit r, bit b);
        rst = r;
        button = b;
        @(negedge clk);
    endtask

    int dcount;

    initial begin
        rst = 1'b1;
        button = 1'b0;
        @(negedge clk);
        drive(1, 0);
        chk("reset_throw", 32'(throw), 32'd9);
        chk("reset_sum", 32'(sum), 32'd2);
        chk("reset_all_equal", 32'(all_equal), 32'd1);
        chk("reset_rolling", 32'(rolling), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        // short press extended to MIN_ROLL advances
        repeat (3) drive(0, 1);
        chk("short_throw_3", 32'(throw), 32'd12);
        chk("short_rolling", 32'(rolling), 32'd1);
        drive(0, 0);
        chk("short_extend_throw", 32'(throw), 32'd13);
        chk("short_extend_done", 32'(done), 32'd0);
        drive(0, 0);
        chk("short_cap_done", 32'(done), 32'd1);
        chk("short_cap_sum", 32'(sum), 32'd6);
        chk("short_cap_eq", 32'(all_equal), 32'd0);
        chk("short_cap_rolling", 32'(rolling), 32'd0);
        drive(0, 0);
        chk("short_done_clear", 32'(done), 32'd0);
        chk("short_sum_hold", 32'(sum), 32'd6);

        // cascade wrap, then reset/button priority
        drive(1, 0);
        repeat (6) drive(0, 1);
        chk("cascade_throw", 32'(throw), 32'd17);
        drive(0, 0);
        chk("cascade_done", 32'(done), 32'd1);
        chk("cascade_sum", 32'(sum), 32'd3);
        chk("cascade_eq", 32'(all_equal), 32'd0);
        drive(1, 1);
        chk("prio_throw", 32'(throw), 32'd9);
        chk("prio_rolling", 32'(rolling), 32'd0);
        chk("prio_sum", 32'(sum), 32'd2);

        // full wrap after FACES^NDICE steps
        drive(1, 0);
        repeat (36) drive(0, 1);
        chk("wrap_throw", 32'(throw), 32'd9);
        chk("wrap_rolling", 32'(rolling), 32'd1);
        drive(0, 0);
        chk("wrap_done", 32'(done), 32'd1);
        chk("wrap_sum", 32'(sum), 32'd2);
        chk("wrap_eq", 32'(all_equal), 32'd1);

        // reset mid-roll
        drive(1, 0);
        dcount = 0;
        for (int e = 1; e <= 10; e++) begin
            drive(e == 5, 1);
            dcount += int'(done);
            if (e == 5) begin
                chk("midrst_throw", 32'(throw), 32'd9);
                chk("midrst_rolling", 32'(rolling), 32'd0);
            end
            if (e == 6) begin
                chk("midrst_resume_throw", 32'(throw), 32'd10);
                chk("midrst_resume_rolling", 32'(rolling), 32'd1);
            end
        end
        chk("midrst_no_done", 32'(dcount), 32'd0);
        drive(0, 0);
        chk("midrst_cap_sum", 32'(sum), 32'd7);
        repeat (3) drive(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
